uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Controller that sits on the receive side between the UART frame receiver and downstream VGA logic. It owns the receiver's configuration registers (parity enable, parity type, stop bits and frame length) and drives them as outputs. It separates in-band escape commands from data frames and buffers data frames in a small FIFO with a valid/ready handshake. It runs in the 16x-baud clock domain.

## Interface
- FIFO_DEPTH, 8, data FIFO entries; power of two, at least 2
- ESC_TIMEOUT, 16'd2560, clk_16bd cycles to wait for the byte after ESC (used only with the timeout feature)

- clk_16bd  in  1  16x baud clock; the block's only clock
- rst  in  1  reset, synchronous, active-high
- frame  in  9  received frame from the receiver, LSB-first data, zero-extended
- frame_valid  in  1  receiver frame-valid
- parity  out  1  receiver parity enable
- parity_type  out  1  0 = even, 1 = odd
- stop_bits  out  1  0 = one stop bit, 1 = two stop bits
- frame_length  out  4  data bits per frame, range 5..9
- data_out  out  9  head of the data FIFO
- data_valid  out  1  FIFO not empty
- data_ready  in  1  downstream accepts data_out
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf
- cmd_err  out  1  one-cycle pulse for a rejected command
- cfg_update  out  1  one-cycle pulse when the config registers change

## Operation
- Frame acceptance:
  - fv_q is a register that holds the previous cycle's frame_valid.
  - A frame is accepted when frame_valid=1 and fv_q=0 (rising edge).
  - fv_q resets to 1, so a frame_valid already high when reset is released is not accepted.
- ESC match: frame[8]=0 and frame[7:0]=8'h1B.
- State IDLE:
  - Accepted frame that matches ESC → state ESC_WAIT; the ESC frame itself is not stored.
  - Any other accepted frame → pushed to the FIFO.
- State ESC_WAIT, next accepted frame:
  - ESC again → 9'h01B pushed to the FIFO as a literal; → IDLE.
  - frame[7]=0 → config command:
    - Field mapping: frame_length=frame[3:0], parity=frame[4], parity_type=frame[5], stop_bits=frame[6].
    - frame[3:0] in 5..9 → all four config registers written together; cfg_update pulses.
    - frame[3:0] outside 5..9 → no change; cmd_err pulses.
    - → IDLE in both cases.
  - frame[7]=1 → frame discarded; cmd_err pulses; → IDLE.
- FIFO behaviour:
  - Push while full with no pop in the same cycle → frame dropped, ovf set.
  - Push and pop in the same cycle while full → both succeed; the count is unchanged.
  - Pop occurs when data_valid=1 and data_ready=1.
- ovf:
  - ovf_clr clears ovf.
  - A set event in the same cycle as ovf_clr wins, so ovf ends at 1.
- Reset values:
  - State IDLE; FIFO empty.
  - data_valid=0, data_out=0.
  - ovf=0, cmd_err=0, cfg_update=0.
  - Config 8N1: frame_length=4'd8, parity=0, parity_type=0, stop_bits=0.
- Reset mid-operation (including in ESC_WAIT or with FIFO data pending): everything returns to the reset values on the next edge; FIFO contents are lost.

## Timing
- Acceptance is evaluated at clock edge k, where frame_valid=1 and fv_q=0.
- FIFO push happens at edge k. With the FIFO previously empty, data_valid=1 and data_out are valid in the cycle after edge k (1-cycle latency).
- Config registers update at edge k; cfg_update is high for exactly the cycle after edge k. The receiver is idle at that moment, so the new config applies from the next start bit.
- cmd_err is high for exactly one cycle after the offending edge.
- data_out is the registered FIFO head and stays stable while data_valid=1 and data_ready=0.
- Pointers wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.

## Configuration
- Macro UART_RX_CTRL_TIMEOUT_EN compiles in the escape timeout.
- With the macro:
  - A 16-bit counter clears on entry to ESC_WAIT and increments every cycle while in ESC_WAIT.
  - When the counter reaches ESC_TIMEOUT-1 with no accepted frame, the state returns to IDLE, the pending ESC is discarded and cmd_err pulses.
  - If a frame is accepted in the same cycle as the timeout, the frame is processed and the timeout is ignored.
- Without the macro: ESC_WAIT waits indefinitely; no counter is built.

## Structure
- Package uart_pkg holds:
  - the uart_cfg_t struct (frame_length, parity, parity_type, stop_bits);
  - UART_ESC = 8'h1B;
  - the CFG field bit positions;
  - UART_CFG_RST (8N1);
  - the state enum (IDLE, ESC_WAIT).
- One sub-module, uart_frame_fifo:
  - synchronous, show-ahead, parameterised by depth and width;
  - provides push, pop, full, empty and overflow-on-push.
- Edge detection, the command decoder, the config registers and the timeout counter stay in uart_rx_ctrl.

## Test plan
- Reset, then frames 0x041 and 0x042 with data_ready=1 → data_out shows 0x041 then 0x042, each one cycle after its frame_valid edge; config outputs remain 8N1.
- ESC then 0x78 → frame_length=8, parity=1, parity_type=1, stop_bits=1; one cfg_update pulse; nothing pushed to the FIFO.
- ESC then 0x0C (length 12) → config unchanged, one cmd_err pulse. ESC, ESC → 0x01B appears on data_out.
- data_ready=0 and FIFO_DEPTH+1 data frames → first 8 frames retained in order, ovf=1. Then ovf_clr together with a push while still full → ovf stays 1.
- frame_valid held high across reset release → no push. A 3-cycle frame_valid pulse → exactly one push.
- UART_RX_CTRL_TIMEOUT_EN defined, ESC_TIMEOUT=16: ESC followed by 20 idle cycles → cmd_err at the 16th cycle; a later 0x078 is stored as data, not as a command.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_pkg;

  typedef struct packed {
    logic [3:0] frame_length;
    logic       parity;
    logic       parity_type;
    logic       stop_bits;
  } uart_cfg_t;

  localparam logic [7:0] UART_ESC = 8'h1B;

  // Bit positions inside the byte that follows ESC
  localparam int CFG_LEN_LSB   = 0;
  localparam int CFG_LEN_MSB   = 3;
  localparam int CFG_PAR_BIT   = 4;
  localparam int CFG_PTYPE_BIT = 5;
  localparam int CFG_STOP_BIT  = 6;
  localparam int CFG_DATA_BIT  = 7;

  localparam uart_cfg_t UART_CFG_RST = '{
    frame_length: 4'd8,
    parity:       1'b0,
    parity_type:  1'b0,
    stop_bits:    1'b0
  };

  typedef enum logic {
    IDLE     = 1'b0,
    ESC_WAIT = 1'b1
  } uart_state_t;

  function automatic logic cfg_len_ok(input logic [3:0] len);
    return (len >= 4'd5) && (len <= 4'd9);
  endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Synchronous show-ahead FIFO; rdata is the current head and reads as zero when empty.
module uart_frame_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: escape-command decode, receiver config registers, data FIFO.
// Define UART_RX_CTRL_TIMEOUT_EN to build the escape timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] ESC_TIMEOUT = 16'd2560
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic       parity,
  output logic       parity_type,
  output logic       stop_bits,
  output logic [3:0] frame_length,
  output logic [8:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       cmd_err,
  output logic       cfg_update
);

  uart_state_t state, state_nx;
  uart_cfg_t   cfg_q;
  logic        fv_q;
  logic        accept;
  logic        is_esc;
  logic        timeout;
  logic        push;
  logic [8:0]  push_data;
  logic        cfg_we;
  logic        err_set;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_ovf;

  assign accept = frame_valid & ~fv_q;
  assign is_esc = (frame[8] == 1'b0) && (frame[7:0] == UART_ESC);

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [15:0] esc_cnt;

  // Held at zero outside ESC_WAIT, so it starts from zero on every entry
  always_ff @(posedge clk_16bd) begin
    if (rst || state != ESC_WAIT) esc_cnt <= '0;
    else                          esc_cnt <= esc_cnt + 16'd1;
  end

  assign timeout = (state == ESC_WAIT) && (esc_cnt == ESC_TIMEOUT - 16'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^ESC_TIMEOUT;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk_16bd) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && is_esc) state_nx = ESC_WAIT;
      ESC_WAIT: if (accept || timeout) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = frame;
    cfg_we    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: if (accept && !is_esc) push = 1'b1;
      ESC_WAIT: begin
        if (accept) begin
          if (is_esc) begin
            push      = 1'b1;
            push_data = {1'b0, UART_ESC};
          end else if (!frame[CFG_DATA_BIT]) begin
            if (cfg_len_ok(frame[CFG_LEN_MSB:CFG_LEN_LSB])) cfg_we  = 1'b1;
            else                                            err_set = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else if (timeout) begin
          err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      fv_q       <= 1'b1;
      cfg_q      <= UART_CFG_RST;
      cmd_err    <= 1'b0;
      cfg_update <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      fv_q       <= frame_valid;
      cmd_err    <= err_set;
      cfg_update <= cfg_we;
      if (cfg_we) begin
        cfg_q.frame_length <= frame[CFG_LEN_MSB:CFG_LEN_LSB];
        cfg_q.parity       <= frame[CFG_PAR_BIT];
        cfg_q.parity_type  <= frame[CFG_PTYPE_BIT];
        cfg_q.stop_bits    <= frame[CFG_STOP_BIT];
      end
      // A new overflow beats a simultaneous clear
      if (fifo_ovf)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign frame_length = cfg_q.frame_length;
  assign parity       = cfg_q.parity;
  assign parity_type  = cfg_q.parity_type;
  assign stop_bits    = cfg_q.stop_bits;
  assign data_valid   = ~fifo_empty;

  uart_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk      (clk_16bd),
    .rst      (rst),
    .push     (push),
    .pop      (data_ready),
    .wdata    (push_data),
    .rdata    (data_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int          DEPTH  = 8;
  localparam logic [15:0] TB_TMO = 16'd16;

  logic       clk_16bd = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       parity, parity_type, stop_bits;
  logic [3:0] frame_length;
  logic [8:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       cmd_err;
  logic       cfg_update;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .ESC_TIMEOUT (TB_TMO)
  ) dut (
    .clk_16bd     (clk_16bd),
    .rst          (rst),
    .frame        (frame),
    .frame_valid  (frame_valid),
    .parity       (parity),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .frame_length (frame_length),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr),
    .cmd_err      (cmd_err),
    .cfg_update   (cfg_update)
  );

  always #5 clk_16bd = ~clk_16bd;

  // Reference model: pending-escape flag, a queue for the FIFO, plain config fields
  logic [8:0] mq[$];
  bit         m_fvq = 1'b1;
  bit         m_esc = 1'b0;
  int         m_esc_edge = 0;
  int         edge_no = 0;
  logic [3:0] m_len = 4'd8;
  bit         m_par = 0, m_pt = 0, m_sb = 0, m_ovf = 0, m_err = 0, m_upd = 0;

  task automatic model_step(input bit fv, input logic [8:0] f, input bit rdy,
                            input bit clr, input bit r);
    bit acc, popd, do_push, err, upd, ovfset;
    logic [8:0] pd;
    edge_no++;
    if (r) begin
      mq.delete();
      m_fvq = 1; m_esc = 0; m_len = 4'd8; m_par = 0; m_pt = 0; m_sb = 0;
      m_ovf = 0; m_err = 0; m_upd = 0;
    end else begin
      acc = fv && !m_fvq;
      m_fvq = fv;
      popd = (mq.size() != 0) && rdy;
      do_push = 0; err = 0; upd = 0; pd = f;
      if (acc) begin
        if (!m_esc) begin
          if (f == 9'h01B) begin m_esc = 1; m_esc_edge = edge_no; end
          else do_push = 1;
        end else begin
          m_esc = 0;
          if (f == 9'h01B) do_push = 1;
          else if (f[7] == 1'b0) begin
            if (f[3:0] >= 4'd5 && f[3:0] <= 4'd9) begin
              m_len = f[3:0]; m_par = f[4]; m_pt = f[5]; m_sb = f[6]; upd = 1;
            end else err = 1;
          end else err = 1;
        end
      end
`ifdef UART_RX_CTRL_TIMEOUT_EN
      else if (m_esc && (edge_no - m_esc_edge) == int'(TB_TMO)) begin
        m_esc = 0; err = 1;
      end
`endif
      ovfset = do_push && (mq.size() == DEPTH) && !popd;
      if (popd) void'(mq.pop_front());
      if (do_push && !ovfset) mq.push_back(pd);
      m_ovf = ovfset ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_err = err;
      m_upd = upd;
    end
  endtask

  // Drive inputs (just after a falling edge), step the model, return at the next falling edge
  task automatic cycle(input bit fv, input logic [8:0] f, input bit rdy, input bit clr, input bit r);
    frame_valid = fv; frame = f; data_ready = rdy; ovf_clr = clr; rst = r;
    model_step(fv, f, rdy, clr, r);
    @(posedge clk_16bd);
    @(negedge clk_16bd);
  endtask

  function automatic logic [8:0] m_head();
    logic [8:0] h;
    h = (mq.size() != 0) ? mq[0] : 9'h000;
    return h;
  endfunction

  task automatic test_reset();
    cycle(0, 9'h0, 0, 0, 1);
    cycle(0, 9'h0, 0, 0, 1);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (data_out !== 9'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", data_out); end
    checks++; if ({ovf, cmd_err, cfg_update} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ovf, cmd_err, cfg_update}); end
    checks++; if ({frame_length, parity, parity_type, stop_bits} !== {4'd8, 3'b000}) begin
      errors++; $display("FAIL reset_cfg got=%h/%b%b%b exp=8/000", frame_length, parity, parity_type, stop_bits); end
    cycle(0, 9'h0, 0, 0, 0);
  endtask

  task automatic test_data();
    cycle(1, 9'h041, 1, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h041) begin errors++; $display("FAIL data_first got=%b/%h exp=1/041", data_valid, data_out); end
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h042, 1, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h042) begin errors++; $display("FAIL data_second got=%b/%h exp=1/042", data_valid, data_out); end
    cycle(0, 9'h0, 1, 0, 0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL data_drained got=%b exp=0", data_valid); end
    checks++; if ({frame_length, parity, parity_type, stop_bits} !== {4'd8, 3'b000}) begin
      errors++; $display("FAIL data_cfg_8n1 got=%h/%b%b%b exp=8/000", frame_length, parity, parity_type, stop_bits); end
  endtask

  task automatic test_cfg();
    cycle(1, 9'h01B, 1, 0, 0);
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h078, 1, 0, 0);
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL cfg_pulse got=%b exp=1", cfg_update); end
    checks++; if ({frame_length, parity, parity_type, stop_bits} !== {4'd8, 3'b111}) begin
      errors++; $display("FAIL cfg_value got=%h/%b%b%b exp=8/111", frame_length, parity, parity_type, stop_bits); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL cfg_no_push got=%b exp=0", data_valid); end
    cycle(0, 9'h0, 1, 0, 0);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL cfg_pulse_len got=%b exp=0", cfg_update); end
  endtask

  task automatic test_bad_cmd();
    cycle(1, 9'h01B, 1, 0, 0);
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h00C, 1, 0, 0);
    checks++; if (cmd_err !== 1'b1 || cfg_update !== 1'b0) begin errors++; $display("FAIL bad_len got=%b%b exp=10", cmd_err, cfg_update); end
    checks++; if ({frame_length, parity, parity_type, stop_bits} !== {m_len, m_par, m_pt, m_sb}) begin
      errors++; $display("FAIL bad_len_cfg got=%h exp=%h", {frame_length, parity, parity_type, stop_bits}, {m_len, m_par, m_pt, m_sb}); end
    cycle(0, 9'h0, 1, 0, 0);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL bad_len_pulse got=%b exp=0", cmd_err); end
    cycle(1, 9'h01B, 1, 0, 0);
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h085, 1, 0, 0);
    checks++; if (cmd_err !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL bad_bit7 got=%b%b exp=10", cmd_err, data_valid); end
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h01B, 1, 0, 0);
    cycle(0, 9'h0, 1, 0, 0);
    cycle(1, 9'h01B, 1, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h01B) begin errors++; $display("FAIL esc_literal got=%b/%h exp=1/01b", data_valid, data_out); end
    cycle(0, 9'h0, 1, 0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1, 9'h100 + 9'(i), 0, 0, 0);
      cycle(0, 9'h0, 0, 0, 0);
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    cycle(1, 9'h1AA, 0, 1, 0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_set got=%b exp=1", ovf); end
    cycle(0, 9'h0, 0, 1, 0);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (data_valid !== 1'b1 || data_out !== 9'h100 + 9'(i)) begin
        errors++; $display("FAIL ovf_order[%0d] got=%b/%h exp=1/%h", i, data_valid, data_out, 9'h100 + 9'(i)); end
      cycle(0, 9'h0, 1, 0, 0);
    end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", data_valid); end
  endtask

  task automatic test_fv_edges();
    cycle(1, 9'h055, 0, 0, 1);
    cycle(1, 9'h055, 0, 0, 0);
    cycle(1, 9'h055, 0, 0, 0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL fv_across_reset got=%b exp=0", data_valid); end
    cycle(0, 9'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 9'h066, 0, 0, 0);
    cycle(0, 9'h0, 0, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h066) begin errors++; $display("FAIL long_pulse got=%b/%h exp=1/066", data_valid, data_out); end
    cycle(0, 9'h0, 1, 0, 0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL long_pulse_once got=%b exp=0", data_valid); end
  endtask

  task automatic test_mid_reset();
    cycle(1, 9'h01B, 0, 0, 0);
    cycle(0, 9'h0, 0, 0, 0);
    cycle(1, 9'h031, 0, 0, 0);
    cycle(0, 9'h0, 0, 0, 0);
    cycle(1, 9'h01B, 0, 0, 0);
    cycle(0, 9'h0, 0, 0, 1);
    checks++; if (data_valid !== 1'b0 || {frame_length, parity, parity_type, stop_bits} !== {4'd8, 3'b000}) begin
      errors++; $display("FAIL mid_reset got=%b/%h exp=0/8", data_valid, frame_length); end
    cycle(0, 9'h0, 0, 0, 0);
    cycle(1, 9'h078, 0, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h078 || cfg_update !== 1'b0) begin
      errors++; $display("FAIL mid_reset_esc_lost got=%b/%h/%b exp=1/078/0", data_valid, data_out, cfg_update); end
    cycle(0, 9'h0, 1, 0, 0);
  endtask

  task automatic test_random();
    bit fv, rdy, clr, r;
    logic [8:0] f;
    for (int n = 0; n < 1500; n++) begin
      fv  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0, 1:    f = 9'h01B;
        2:       f = {2'b00, 3'($urandom), 4'($urandom_range(3, 11))};
        default: f = 9'($urandom);
      endcase
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 199) == 0);
      cycle(fv, f, rdy, clr, r);
      checks++; if (data_valid !== (mq.size() != 0) || data_out !== m_head()) begin
        errors++; $display("FAIL rnd_fifo[%0d] got=%b/%h exp=%b/%h", n, data_valid, data_out, mq.size() != 0, m_head()); end
      checks++; if ({frame_length, parity, parity_type, stop_bits} !== {m_len, m_par, m_pt, m_sb}) begin
        errors++; $display("FAIL rnd_cfg[%0d] got=%h exp=%h", n, {frame_length, parity, parity_type, stop_bits}, {m_len, m_par, m_pt, m_sb}); end
      checks++; if ({ovf, cmd_err, cfg_update} !== {m_ovf, m_err, m_upd}) begin
        errors++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", n, {ovf, cmd_err, cfg_update}, {m_ovf, m_err, m_upd}); end
    end
  endtask

`ifdef UART_RX_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    cycle(0, 9'h0, 0, 0, 1);
    cycle(0, 9'h0, 0, 0, 0);
    cycle(1, 9'h01B, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 9'h0, 0, 0, 0);
      checks++; if (cmd_err !== (i == 15)) begin errors++; $display("FAIL timeout_pulse[%0d] got=%b exp=%b", i, cmd_err, i == 15); end
    end
    cycle(1, 9'h078, 0, 0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 9'h078 || cfg_update !== 1'b0) begin
      errors++; $display("FAIL timeout_then_data got=%b/%h/%b exp=1/078/0", data_valid, data_out, cfg_update); end
    cycle(0, 9'h0, 1, 0, 0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data();
    test_cfg();
    test_bad_cmd();
    test_overflow();
    test_fv_edges();
    test_mid_reset();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
